// File: rtl/output_delta_unit_if.sv
// Beat stream into the output-delta stage and delta stream out of it.
// The stage itself connects through the slave modport.
interface output_delta_unit_if #(
    parameter int unsigned width = 16,
    parameter int unsigned lanes = 2
);
    logic                   in_valid;
    logic                   in_ready;
    logic [width*lanes-1:0] a_package;
    logic [lanes-1:0]       y_package;
    logic                   out_valid;
    logic                   out_ready;
    logic [width*lanes-1:0] delta_package;

    modport master (
        output in_valid,
        output a_package,
        output y_package,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  delta_package
    );

    modport slave (
        input  in_valid,
        input  a_package,
        input  y_package,
        input  out_ready,
        output in_ready,
        output out_valid,
        output delta_package
    );
endinterface

// File: rtl/output_delta_unit.sv
// Output-layer error stage: per-lane cross-entropy deltas (a - y) plus per-sample
// argmax prediction, label extraction and running accuracy counters.
module output_delta_unit #(
    parameter int unsigned n         = 8,
    parameter int unsigned z         = 8,
    parameter int unsigned fi        = 4,
    parameter int unsigned width     = 16,
    parameter int unsigned int_bits  = 5,
    parameter int unsigned frac_bits = 10,
    parameter int unsigned cnt_width = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_stats,
    output_delta_unit_if.slave    bus,
    output logic                  sample_done,
    output logic [$clog2(n)-1:0]  pred_idx,
    output logic [$clog2(n)-1:0]  label_idx,
    output logic                  label_ok,
    output logic                  correct,
    output logic [cnt_width-1:0]  sample_cnt,
    output logic [cnt_width-1:0]  correct_cnt
);
    localparam int unsigned L     = z / fi;
    localparam int unsigned Beats = n / L;
    localparam int unsigned BeatW = (Beats > 1) ? $clog2(Beats) : 1;
    localparam int unsigned IdxW  = $clog2(n);

    localparam logic signed [width:0] One    = (width + 1)'(1) << frac_bits;
    localparam logic signed [width:0] Zero   = '0;
    localparam logic signed [width:0] SatMax = {2'b00, {(width - 1){1'b1}}};
    localparam logic signed [width:0] SatMin = {2'b11, {(width - 1){1'b0}}};

    if (((n % L) != 0) || ((int_bits + frac_bits + 1) != width)) begin : g_bad_cfg
        $error("output_delta_unit: inconsistent parameters");
    end

    typedef enum logic [0:0] {StIdle, StAccum} state_e;

    state_e               state_q, state_d;
    logic [BeatW-1:0]     beat_q, beat_d;
    logic [width-1:0]     max_q;
    logic [IdxW-1:0]      max_idx_q;
    logic [IdxW-1:0]      lbl_q;
    logic [1:0]           ycnt_q;

    logic                 out_valid_q;
    logic [width*L-1:0]   delta_q, delta_d;

    logic                 done_q;
    logic [IdxW-1:0]      pred_q, label_q;
    logic                 label_ok_q, correct_q;
    logic [cnt_width-1:0] scnt_q, scnt_d;
    logic [cnt_width-1:0] ccnt_q, ccnt_d;

    logic                 in_ready;
    logic                 accept;
    logic                 last_beat;
    logic                 complete;
    logic                 first;

    logic [width-1:0]     scan_max;
    logic [IdxW-1:0]      scan_idx;
    logic [IdxW-1:0]      scan_lbl;
    logic [1:0]           scan_cnt;
    logic                 scan_ok;
    logic                 scan_correct;
    logic [width-1:0]     lane_a;
    logic [IdxW-1:0]      elem;

    // Single output register: a new beat may enter whenever the held one drains.
    assign in_ready  = !out_valid_q || bus.out_ready;
    assign accept    = bus.in_valid && in_ready;
    assign last_beat = (beat_q == BeatW'(Beats - 1));
    assign complete  = accept && last_beat;
    assign first     = (state_q == StIdle);

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = out_valid_q;
    assign bus.delta_package = delta_q;

    assign sample_done = done_q;
    assign pred_idx    = pred_q;
    assign label_idx   = label_q;
    assign label_ok    = label_ok_q;
    assign correct     = correct_q;
    assign sample_cnt  = scnt_q;
    assign correct_cnt = ccnt_q;

    for (genvar k = 0; k < L; k++) begin : g_lane
        logic signed [width:0] diff;
        assign diff = $signed({1'b0, bus.a_package[width*k +: width]})
                    - (bus.y_package[k] ? One : Zero);
        assign delta_d[width*k +: width] = (diff > SatMax) ? SatMax[width-1:0] :
                                           (diff < SatMin) ? SatMin[width-1:0] :
                                                             diff[width-1:0];
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        if (accept) begin
            if (last_beat) begin
                state_d = StIdle;
                beat_d  = '0;
            end else begin
                state_d = StAccum;
                beat_d  = beat_q + 1'b1;
            end
        end
    end

    // Fold this beat's lanes into the running argmax and label; the first beat
    // of a sample starts fresh so stale state from the last sample never leaks.
    always_comb begin
        scan_max = max_q;
        scan_idx = max_idx_q;
        scan_lbl = lbl_q;
        scan_cnt = ycnt_q;
        lane_a   = '0;
        elem     = '0;
        if (first) begin
            scan_lbl = '0;
            scan_cnt = '0;
        end
        for (int unsigned k = 0; k < L; k++) begin
            elem   = IdxW'(32'(beat_q) * L + k);
            lane_a = bus.a_package[width*k +: width];
            if ((first && (k == 0)) || (lane_a > scan_max)) begin
                scan_max = lane_a;
                scan_idx = elem;
            end
            if (bus.y_package[k]) begin
                if (scan_cnt == 2'd0) scan_lbl = elem;
                if (scan_cnt != 2'd2) scan_cnt = scan_cnt + 2'd1;
            end
        end
        scan_ok      = (scan_cnt == 2'd1);
        scan_correct = scan_ok && (scan_idx == scan_lbl);
    end

    // Clear takes priority over a coincident completion.
    always_comb begin
        scnt_d = scnt_q;
        ccnt_d = ccnt_q;
        if (clear_stats) begin
            scnt_d = '0;
            ccnt_d = '0;
        end else if (complete) begin
            if (~&scnt_q) scnt_d = scnt_q + 1'b1;
            if (scan_correct && ~&ccnt_q) ccnt_d = ccnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            delta_q     <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            delta_q     <= delta_d;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            max_q     <= '0;
            max_idx_q <= '0;
            lbl_q     <= '0;
            ycnt_q    <= '0;
        end else if (accept) begin
            max_q     <= scan_max;
            max_idx_q <= scan_idx;
            lbl_q     <= scan_lbl;
            ycnt_q    <= scan_cnt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q     <= 1'b0;
            pred_q     <= '0;
            label_q    <= '0;
            label_ok_q <= 1'b0;
            correct_q  <= 1'b0;
            scnt_q     <= '0;
            ccnt_q     <= '0;
        end else begin
            done_q <= complete;
            scnt_q <= scnt_d;
            ccnt_q <= ccnt_d;
            if (complete) begin
                pred_q     <= scan_idx;
                label_q    <= scan_lbl;
                label_ok_q <= scan_ok;
                correct_q  <= scan_correct;
            end
        end
    end
endmodule

// File: tb/tb_output_delta_unit.sv
// Directed bench for output_delta_unit: scoreboard of per-beat deltas and
// per-sample results, plus literal checks on hand-worked samples.
module tb_output_delta_unit;
    localparam int N    = 8;
    localparam int Z    = 8;
    localparam int FI   = 4;
    localparam int W    = 16;
    localparam int FRAC = 10;
    localparam int L    = Z / FI;
    localparam int NB   = N / L;
    localparam int CW   = 4;
    localparam int IW   = $clog2(N);
    localparam int MAXC = (1 << CW) - 1;

    typedef struct packed {
        logic [IW-1:0] pred;
        logic [IW-1:0] label;
        logic          ok;
        logic          cor;
        logic [CW-1:0] scnt;
        logic [CW-1:0] ccnt;
    } res_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clear_stats = 1'b0;
    logic sample_done, label_ok, correct;
    logic [IW-1:0] pred_idx, label_idx;
    logic [CW-1:0] sample_cnt, correct_cnt;

    always #5 clk = ~clk;

    output_delta_unit_if #(.width(W), .lanes(L)) bus ();

    output_delta_unit #(
        .n(N), .z(Z), .fi(FI), .width(W), .int_bits(5), .frac_bits(FRAC), .cnt_width(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .clear_stats(clear_stats),
        .bus(bus),
        .sample_done(sample_done),
        .pred_idx(pred_idx),
        .label_idx(label_idx),
        .label_ok(label_ok),
        .correct(correct),
        .sample_cnt(sample_cnt),
        .correct_cnt(correct_cnt)
    );

    int pass_cnt = 0;
    int total_cnt = 0;
    int done_seen = 0;
    int n_exp = 0;
    int m_scnt = 0;
    int m_ccnt = 0;
    int s_a[N];
    bit s_y[N];
    logic [W*L-1:0] exp_delta_q[$];
    res_t exp_res_q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    function automatic logic [W-1:0] model_delta(input int a, input bit y);
        int d;
        d = a - (y ? (1 << FRAC) : 0);
        if (d > 32767) d = 32767;
        if (d < -32768) d = -32768;
        return W'(d);
    endfunction

    function automatic res_t model_result();
        res_t r;
        int best = 0;
        int ny = 0;
        int lbl = 0;
        for (int i = 1; i < N; i++) if (s_a[i] > s_a[best]) best = i;
        for (int i = 0; i < N; i++) begin
            if (s_y[i]) begin
                if (ny == 0) lbl = i;
                ny++;
            end
        end
        r = '0;
        r.pred  = IW'(best);
        r.label = IW'(lbl);
        r.ok    = (ny == 1);
        r.cor   = (ny == 1) && (best == lbl);
        return r;
    endfunction

    function automatic void set_sample(input int a0, input int a1, input int a2, input int a3,
                                       input int a4, input int a5, input int a6, input int a7,
                                       input logic [7:0] y);
        s_a[0] = a0; s_a[1] = a1; s_a[2] = a2; s_a[3] = a3;
        s_a[4] = a4; s_a[5] = a5; s_a[6] = a6; s_a[7] = a7;
        for (int i = 0; i < N; i++) s_y[i] = y[i];
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_beat(input int b, input bit clr);
        logic [W*L-1:0] p;
        res_t r;
        bit accepted = 0;
        bus.in_valid = 1'b1;
        clear_stats = clr;
        for (int k = 0; k < L; k++) begin
            bus.a_package[W*k +: W] = W'(s_a[b*L+k]);
            bus.y_package[k] = s_y[b*L+k];
        end
        for (int t = 0; t < 50 && !accepted; t++) begin
            @(negedge clk);
            if (bus.in_ready) accepted = 1;
        end
        if (!accepted) begin
            total_cnt++;
            $display("FAIL accept_timeout: beat %0d not accepted within 50 cycles", b);
        end else begin
            for (int k = 0; k < L; k++) p[W*k +: W] = model_delta(s_a[b*L+k], s_y[b*L+k]);
            exp_delta_q.push_back(p);
            if (b == NB - 1) begin
                r = model_result();
                if (m_scnt < MAXC) m_scnt++;
                if (r.cor && m_ccnt < MAXC) m_ccnt++;
                if (clr) begin
                    m_scnt = 0;
                    m_ccnt = 0;
                end
                r.scnt = CW'(m_scnt);
                r.ccnt = CW'(m_ccnt);
                exp_res_q.push_back(r);
                n_exp++;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        clear_stats = 1'b0;
    endtask

    task automatic send_sample(input bit clr_last);
        for (int b = 0; b < NB; b++) send_beat(b, clr_last && (b == NB - 1));
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.out_valid) begin
                if (exp_delta_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_delta: got 0x%0h with no beat outstanding",
                             bus.delta_package);
                end else begin
                    check("delta", bus.delta_package, exp_delta_q[0]);
                    if (bus.out_ready) void'(exp_delta_q.pop_front());
                end
            end
            if (sample_done) begin
                done_seen++;
                if (exp_res_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_sample_done: got pred %0d with no sample due",
                             pred_idx);
                end else begin
                    res_t e;
                    e = exp_res_q.pop_front();
                    check("pred_idx", 32'(pred_idx), 32'(e.pred));
                    check("label_idx", 32'(label_idx), 32'(e.label));
                    check("label_ok", 32'(label_ok), 32'(e.ok));
                    check("correct", 32'(correct), 32'(e.cor));
                    check("sample_cnt", 32'(sample_cnt), 32'(e.scnt));
                    check("correct_cnt", 32'(correct_cnt), 32'(e.ccnt));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.a_package = '0;
        bus.y_package = '0;

        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_delta", bus.delta_package, 32'd0);
        check("rst_done", 32'(sample_done), 32'd0);
        check("rst_sample_cnt", 32'(sample_cnt), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        check("model_delta_neg", 32'(model_delta(922, 1)), 32'h0000_FF9A);
        check("model_delta_sat", 32'(model_delta(65535, 0)), 32'h0000_7FFF);

        // Sample A: 0.25 / 0.9 pair on beat 0, label and max at index 1.
        set_sample(256, 922, 10, 20, 30, 40, 50, 60, 8'b0000_0010);
        send_beat(0, 0);
        @(negedge clk);
        check("a_beat0_delta", bus.delta_package, 32'hFF9A_0100);
        @(posedge clk);
        #1;
        for (int b = 1; b < NB; b++) send_beat(b, 0);
        idle(3);

        // Sample B: max and label at index 5.
        set_sample(100, 200, 300, 400, 500, 1000, 600, 700, 8'b0010_0000);
        send_sample(0);
        @(negedge clk);
        check("b_done", 32'(sample_done), 32'd1);
        check("b_pred", 32'(pred_idx), 32'd5);
        check("b_correct", 32'(correct), 32'd1);
        check("b_correct_cnt", 32'(correct_cnt), 32'd2);
        idle(2);

        // Sample C: tie at 1.0 between indices 2 and 6, label 6.
        set_sample(100, 200, 1024, 300, 400, 500, 1024, 600, 8'b0100_0000);
        send_sample(0);
        @(negedge clk);
        check("c_pred", 32'(pred_idx), 32'd2);
        check("c_correct", 32'(correct), 32'd0);
        check("c_sample_cnt", 32'(sample_cnt), 32'd3);
        check("c_correct_cnt", 32'(correct_cnt), 32'd2);
        idle(2);

        // Sample D: sample B data with a 3-cycle downstream stall before beat 2.
        set_sample(100, 200, 300, 400, 500, 1000, 600, 700, 8'b0010_0000);
        send_beat(0, 0);
        send_beat(1, 0);
        bus.out_ready = 1'b0;
        fork
            begin
                @(negedge clk);
                check("d_stall_in_ready", 32'(bus.in_ready), 32'd0);
                check("d_stall_out_valid", 32'(bus.out_valid), 32'd1);
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
            send_beat(2, 0);
        join
        send_beat(3, 0);
        @(negedge clk);
        check("d_pred", 32'(pred_idx), 32'd5);
        check("d_correct", 32'(correct), 32'd1);
        idle(2);

        // Sample E: no label bit, one saturating activation.
        set_sample(100, 200, 300, 65535, 400, 500, 600, 700, 8'b0000_0000);
        send_sample(0);
        @(negedge clk);
        check("e_pred", 32'(pred_idx), 32'd3);
        check("e_label_ok", 32'(label_ok), 32'd0);
        check("e_sample_cnt", 32'(sample_cnt), 32'd5);
        idle(2);

        // Sample F: two label bits.
        set_sample(256, 922, 10, 20, 30, 40, 50, 60, 8'b1000_0001);
        send_sample(0);
        @(negedge clk);
        check("f_label_idx", 32'(label_idx), 32'd0);
        check("f_label_ok", 32'(label_ok), 32'd0);
        check("f_correct", 32'(correct), 32'd0);
        check("f_sample_cnt", 32'(sample_cnt), 32'd6);
        idle(2);

        // Reset after two beats; the partial sample must vanish.
        set_sample(9, 5000, 7, 8, 0, 0, 0, 0, 8'b0000_0010);
        send_beat(0, 0);
        send_beat(1, 0);
        reset = 1'b1;
        exp_delta_q.delete();
        m_scnt = 0;
        m_ccnt = 0;
        @(negedge clk);
        check("r_out_valid", 32'(bus.out_valid), 32'd0);
        check("r_pred", 32'(pred_idx), 32'd0);
        check("r_sample_cnt", 32'(sample_cnt), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        set_sample(1, 2, 3, 4, 5, 6, 900, 7, 8'b0100_0000);
        send_sample(0);
        @(negedge clk);
        check("g_done", 32'(sample_done), 32'd1);
        check("g_pred", 32'(pred_idx), 32'd6);
        check("g_sample_cnt", 32'(sample_cnt), 32'd1);
        idle(2);

        for (int s = 0; s < 16; s++) begin
            for (int i = 0; i < N; i++) begin
                s_a[i] = int'($urandom_range(0, 4095));
                s_y[i] = 1'b0;
            end
            s_y[$urandom_range(0, N - 1)] = 1'b1;
            send_sample(0);
        end
        idle(3);
        check("sat_sample_cnt", 32'(sample_cnt), 32'(MAXC));

        // clear_stats on the completing beat wins over the increment.
        set_sample(256, 922, 10, 20, 30, 40, 50, 60, 8'b0000_0010);
        send_sample(1);
        @(negedge clk);
        check("clr_done", 32'(sample_done), 32'd1);
        check("clr_sample_cnt", 32'(sample_cnt), 32'd0);
        check("clr_correct_cnt", 32'(correct_cnt), 32'd0);
        idle(5);

        check("deltas_drained", 32'(exp_delta_q.size()), 32'd0);
        check("done_count", 32'(done_seen), 32'(n_exp));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
